// File: rtl/mesi_isc_tb_main_mem.sv
// Main-memory responder for the four MESI ISC testbench mbus ports.
// Optional per-port access statistics: define MESI_ISC_TB_MEM_STAT_EN.
module mesi_isc_tb_main_mem #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MBUS_CMD_WIDTH = 3,
  parameter int MEM_DEPTH      = 16,
  parameter int MEM_AW         = 4,
  parameter int MEM_LATENCY    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd0,
  input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd1,
  input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd2,
  input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd3,
  input  logic [ADDR_WIDTH-1:0]     mbus_addr0,
  input  logic [ADDR_WIDTH-1:0]     mbus_addr1,
  input  logic [ADDR_WIDTH-1:0]     mbus_addr2,
  input  logic [ADDR_WIDTH-1:0]     mbus_addr3,
  input  logic [DATA_WIDTH-1:0]     mbus_data_wr0,
  input  logic [DATA_WIDTH-1:0]     mbus_data_wr1,
  input  logic [DATA_WIDTH-1:0]     mbus_data_wr2,
  input  logic [DATA_WIDTH-1:0]     mbus_data_wr3,
  output logic [DATA_WIDTH-1:0]     mbus_data_rd,
  output logic [3:0]                mbus_ack_memory,
  output logic                      busy
`ifdef MESI_ISC_TB_MEM_STAT_EN
  ,
  output logic [31:0]               stat_rd0,
  output logic [31:0]               stat_rd1,
  output logic [31:0]               stat_rd2,
  output logic [31:0]               stat_rd3,
  output logic [31:0]               stat_wr0,
  output logic [31:0]               stat_wr1,
  output logic [31:0]               stat_wr2,
  output logic [31:0]               stat_wr3,
  output logic [31:0]               stat_oor
`endif
);

  localparam logic [MBUS_CMD_WIDTH-1:0] CMD_WR = MBUS_CMD_WIDTH'(1);
  localparam logic [MBUS_CMD_WIDTH-1:0] CMD_RD = MBUS_CMD_WIDTH'(2);
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK, S_RECOVER} state_t;

  state_t                    state_q;
  logic [1:0]                ptr_q;
  logic [1:0]                port_q;
  logic [MBUS_CMD_WIDTH-1:0] cmd_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [3:0]                ack_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic                      busy_q;
  logic [DATA_WIDTH-1:0]     mem_q [MEM_DEPTH];

  logic [MBUS_CMD_WIDTH-1:0] cmd_a   [4];
  logic [ADDR_WIDTH-1:0]     addr_a  [4];
  logic [DATA_WIDTH-1:0]     wdata_a [4];

  assign cmd_a[0]   = mbus_cmd0;
  assign cmd_a[1]   = mbus_cmd1;
  assign cmd_a[2]   = mbus_cmd2;
  assign cmd_a[3]   = mbus_cmd3;
  assign addr_a[0]  = mbus_addr0;
  assign addr_a[1]  = mbus_addr1;
  assign addr_a[2]  = mbus_addr2;
  assign addr_a[3]  = mbus_addr3;
  assign wdata_a[0] = mbus_data_wr0;
  assign wdata_a[1] = mbus_data_wr1;
  assign wdata_a[2] = mbus_data_wr2;
  assign wdata_a[3] = mbus_data_wr3;

  logic       gnt_vld;
  logic [1:0] gnt_port;
  logic [1:0] cand;

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_port = '0;
    cand     = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!gnt_vld && (cmd_a[cand] == CMD_WR || cmd_a[cand] == CMD_RD)) begin
        gnt_vld  = 1'b1;
        gnt_port = cand;
      end
    end
  end

  // With zero latency the ack is issued at the grant edge, so the transaction
  // is taken straight from the inputs instead of the latched copy.
  logic [1:0]                svc_port;
  logic [MBUS_CMD_WIDTH-1:0] svc_cmd;
  logic [ADDR_WIDTH-1:0]     svc_addr;
  logic [DATA_WIDTH-1:0]     svc_wdata;
  logic                      svc_in_range;
  logic [MEM_AW-1:0]         svc_idx;
  logic                      do_ack;

  always_comb begin
    svc_port  = port_q;
    svc_cmd   = cmd_q;
    svc_addr  = addr_q;
    svc_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      svc_port  = gnt_port;
      svc_cmd   = cmd_a[gnt_port];
      svc_addr  = addr_a[gnt_port];
      svc_wdata = wdata_a[gnt_port];
    end
    svc_in_range = svc_addr < ADDR_WIDTH'(MEM_DEPTH);
    svc_idx      = svc_addr[MEM_AW-1:0];
    do_ack       = (state_q == S_BUSY && cnt_q == '0) ||
                   (MEM_LATENCY == 0 && state_q == S_IDLE && gnt_vld);
  end

`ifdef MESI_ISC_TB_MEM_STAT_EN
  logic [31:0] st_rd_q [4];
  logic [31:0] st_wr_q [4];
  logic [31:0] st_oor_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      port_q  <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
`ifdef MESI_ISC_TB_MEM_STAT_EN
      for (int unsigned i = 0; i < 4; i++) begin
        st_rd_q[i] <= '0;
        st_wr_q[i] <= '0;
      end
      st_oor_q <= '0;
`endif
    end else begin
      ack_q   <= '0;
      rdata_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (gnt_vld) begin
            port_q  <= gnt_port;
            cmd_q   <= cmd_a[gnt_port];
            addr_q  <= addr_a[gnt_port];
            wdata_q <= wdata_a[gnt_port];
            ptr_q   <= gnt_port + 2'd1;
            busy_q  <= 1'b1;
            if (MEM_LATENCY == 0) begin
              state_q <= S_ACK;
            end else begin
              state_q <= S_BUSY;
              cnt_q   <= CNT_W'(MEM_LATENCY - 1);
            end
          end
        end
        S_BUSY: begin
          if (cnt_q == '0) state_q <= S_ACK;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        S_ACK:   state_q <= S_RECOVER;
        S_RECOVER: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase

      if (do_ack) begin
        ack_q <= 4'b0001 << svc_port;
        if (svc_cmd == CMD_RD && svc_in_range) rdata_q <= mem_q[svc_idx];
        if (svc_cmd == CMD_WR && svc_in_range) mem_q[svc_idx] <= svc_wdata;
`ifdef MESI_ISC_TB_MEM_STAT_EN
        if (svc_cmd == CMD_RD && st_rd_q[svc_port] != '1)
          st_rd_q[svc_port] <= st_rd_q[svc_port] + 32'd1;
        if (svc_cmd == CMD_WR && st_wr_q[svc_port] != '1)
          st_wr_q[svc_port] <= st_wr_q[svc_port] + 32'd1;
        if (!svc_in_range && st_oor_q != '1)
          st_oor_q <= st_oor_q + 32'd1;
`endif
      end
    end
  end

  assign mbus_data_rd    = rdata_q;
  assign mbus_ack_memory = ack_q;
  assign busy            = busy_q;

`ifdef MESI_ISC_TB_MEM_STAT_EN
  assign stat_rd0 = st_rd_q[0];
  assign stat_rd1 = st_rd_q[1];
  assign stat_rd2 = st_rd_q[2];
  assign stat_rd3 = st_rd_q[3];
  assign stat_wr0 = st_wr_q[0];
  assign stat_wr1 = st_wr_q[1];
  assign stat_wr2 = st_wr_q[2];
  assign stat_wr3 = st_wr_q[3];
  assign stat_oor = st_oor_q;
`endif

endmodule
